// File: rtl/mem_arbiter_stall.sv
// rtl/mem_arbiter_stall.sv - single-port memory front end arbitrating IF fetch and MEM load/store, with stall generation
module mem_arbiter_stall #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_re,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_FETCH} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                dm_done_q, dm_done_d;
  logic                if_done_q, if_done_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic dm_need, if_need, dm_ack, if_ack, stall;

  always_comb begin
    dm_need = (dm_re | dm_we) & ~dm_done_q;
    if_need = if_req & ~if_done_q;
    // An ack only counts while our own request is outstanding, so stray acks are ignored.
    dm_ack  = mem_req_q & mem_ack & (state_q == ST_DATA);
    if_ack  = mem_req_q & mem_ack & (state_q == ST_FETCH);
    stall   = (dm_need & ~dm_ack) | (if_need & ~if_ack);
  end

  always_comb begin
    mem_stall    = stall;
    mem_req      = mem_req_q;
    mem_we       = mem_we_q;
    mem_addr     = mem_addr_q;
    mem_wdata    = mem_wdata_q;
    stall_cycles = stall_cnt_q;
    if_rdata     = if_ack ? mem_rdata : if_rdata_q;
    dm_rdata     = (dm_ack & ~mem_we_q) ? mem_rdata : dm_rdata_q;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    dm_done_d   = dm_done_q;
    if_done_d   = if_done_q;

    case (state_q)
      ST_IDLE: begin
        if (dm_need) begin
          state_d     = ST_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
        end else if (if_need) begin
          state_d    = ST_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
        end
      end
      ST_DATA: begin
        if (dm_ack) begin
          mem_req_d = 1'b0;
          dm_done_d = 1'b1;
          if (!mem_we_q) dm_rdata_d = mem_rdata;
          state_d = if_need ? ST_FETCH : ST_IDLE;
        end
      end
      ST_FETCH: begin
        // Entered straight from DATA with mem_req low: issue the fetch one cycle after the data ack.
        if (!mem_req_q) begin
          if (if_need) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (if_ack) begin
          mem_req_d  = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!stall) begin
      dm_done_d = 1'b0;
      if_done_d = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      dm_done_q   <= 1'b0;
      if_done_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_done_q   <= dm_done_d;
      if_done_q   <= if_done_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_stall.sv
// tb/tb_mem_arbiter_stall.sv - directed scoreboard bench for mem_arbiter_stall with a latency-programmable memory model
module tb_mem_arbiter_stall;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_re, dm_we, mem_ack;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, stall_cycles;
  logic        mem_stall, mem_req, mem_we;

  logic [15:0] s_if_rdata, s_dm_rdata, s_mem_addr, s_mem_wdata;
  logic        s_mem_stall, s_mem_req, s_mem_we;
  logic [3:0]  s_stall_cycles;

  mem_arbiter_stall #(.ADDR_W(16), .DATA_W(16), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .mem_stall(mem_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_cycles(stall_cycles)
  );

  // Narrow-counter twin sharing all inputs, used to reach saturation quickly.
  mem_arbiter_stall #(.ADDR_W(16), .DATA_W(16), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(s_if_rdata),
    .dm_re(dm_re), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(s_dm_rdata),
    .mem_stall(s_mem_stall), .mem_req(s_mem_req), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_cycles(s_stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  acc_t        exp_acc[$];
  logic [15:0] exp_dm[$];
  logic [15:0] exp_if[$];
  logic [15:0] mem [0:255];
  int          checks = 0;
  int          failures = 0;
  int          lat = 1;
  int          age = 0;
  int          rises = 0;
  int          r0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory side: runs once per cycle just after the edge, when DUT registered outputs are stable.
  task automatic mem_model();
    acc_t e;
    mem_ack = 1'b0;
    if (mem_req !== 1'b1) begin
      age = 0;
      return;
    end
    if (age == 0) begin
      age = 1;
      rises++;
      check("acc_pending", exp_acc.size() != 0, 1);
      if (exp_acc.size() != 0) begin
        e = exp_acc.pop_front();
        check("acc_we", mem_we, e.we);
        check("acc_addr", mem_addr, e.addr);
        if (e.we) check("acc_wdata", mem_wdata, e.wdata);
      end
    end else begin
      age++;
    end
    if (age > lat) begin
      mem_ack = 1'b1;
      if (mem_we) mem[mem_addr[7:0]] = mem_wdata;
      else mem_rdata = mem[mem_addr[7:0]];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    mem_model();
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic run_op(input string tag, input int exp_len, input bit chk_dm, input bit chk_if);
    int n = 0;
    #1;
    while (mem_stall === 1'b1 && n < 100) begin
      n++;
      next_cycle();
      #1;
    end
    check({tag, "_stall_len"}, n, exp_len);
    if (chk_dm) check({tag, "_dm_rdata"}, dm_rdata, exp_dm.pop_front());
    if (chk_if) check({tag, "_if_rdata"}, if_rdata, exp_if.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    clear_inputs();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h40] = 16'h1234;
    mem[8'h20] = 16'hABCD;

    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_stall_cycles", stall_cycles, 0);
    check("rst_mem_stall", mem_stall, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_if_rdata", if_rdata, 0);

    next_cycle(); next_cycle(); next_cycle();
    #1;
    check("idle_mem_req", mem_req, 0);
    check("idle_mem_stall", mem_stall, 0);
    check("idle_no_traffic", rises, 0);

    // Load with ack two cycles after mem_req rises: three stall cycles.
    next_cycle();
    lat = 2;
    dm_re = 1'b1; dm_addr = 16'h0040;
    exp_acc.push_back('{1'b0, 16'h0040, 16'h0000});
    exp_dm.push_back(16'h1234);
    run_op("load", 3, 1, 0);
    next_cycle();
    clear_inputs();
    #1;
    check("post_load_mem_req", mem_req, 0);
    check("post_load_mem_stall", mem_stall, 0);

    // Store and fetch presented together: write first, then fetch.
    next_cycle();
    lat = 1;
    if_req = 1'b1; if_addr = 16'h0020;
    dm_we = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
    exp_acc.push_back('{1'b1, 16'h0010, 16'hBEEF});
    exp_acc.push_back('{1'b0, 16'h0020, 16'h0000});
    exp_if.push_back(16'hABCD);
    r0 = rises;
    run_op("wr_fetch", 5, 0, 1);
    check("wr_fetch_pulses", rises - r0, 2);
    check("wr_fetch_memword", mem[8'h10], 16'hBEEF);
    next_cycle();
    clear_inputs();

    // Store then load of the same address on the next pipeline advance.
    mem[8'h10] = 16'h0000;
    next_cycle();
    dm_we = 1'b1; dm_addr = 16'h0010; dm_wdata = 16'hBEEF;
    exp_acc.push_back('{1'b1, 16'h0010, 16'hBEEF});
    r0 = rises;
    run_op("store", 2, 0, 0);
    next_cycle();
    dm_we = 1'b0; dm_re = 1'b1;
    exp_acc.push_back('{1'b0, 16'h0010, 16'h0000});
    exp_dm.push_back(16'hBEEF);
    run_op("load_after_store", 2, 1, 0);
    check("store_load_pulses", rises - r0, 2);
    next_cycle();
    clear_inputs();

    // dm_re and dm_we together: one write, load data register untouched.
    next_cycle();
    dm_re = 1'b1; dm_we = 1'b1; dm_addr = 16'h0030; dm_wdata = 16'h5A5A;
    exp_acc.push_back('{1'b1, 16'h0030, 16'h5A5A});
    exp_dm.push_back(16'hBEEF);
    r0 = rises;
    run_op("re_we", 2, 1, 0);
    check("re_we_pulses", rises - r0, 1);
    check("re_we_memword", mem[8'h30], 16'h5A5A);
    next_cycle();
    clear_inputs();

    // Reset while the data access is outstanding, then a stray ack.
    next_cycle();
    lat = 6;
    dm_re = 1'b1; dm_addr = 16'h0040;
    exp_acc.push_back('{1'b0, 16'h0040, 16'h0000});
    next_cycle();
    next_cycle();
    #1;
    check("abort_req_up", mem_req, 1);
    check("abort_stall_up", mem_stall, 1);
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    #1;
    check("abort_mem_req", mem_req, 0);
    check("abort_stall_cycles", stall_cycles, 0);
    check("abort_sat_cycles", s_stall_cycles, 0);
    check("abort_mem_stall", mem_stall, 0);
    r0 = rises;
    next_cycle();
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    #1;
    check("late_ack_stall", mem_stall, 0);
    check("late_ack_dm_rdata", dm_rdata, 0);
    check("late_ack_if_rdata", if_rdata, 0);
    next_cycle();
    #1;
    check("late_ack_mem_req", mem_req, 0);
    check("late_ack_no_traffic", rises - r0, 0);

    // Short load to seed both counters, then a long one to saturate the narrow twin.
    next_cycle();
    lat = 1;
    dm_re = 1'b1; dm_addr = 16'h0040;
    exp_acc.push_back('{1'b0, 16'h0040, 16'h0000});
    exp_dm.push_back(16'h1234);
    run_op("cnt_load", 2, 1, 0);
    check("cnt_main", stall_cycles, 2);
    check("cnt_sat", s_stall_cycles, 2);
    next_cycle();
    clear_inputs();

    next_cycle();
    lat = 20;
    dm_re = 1'b1; dm_addr = 16'h0020;
    exp_acc.push_back('{1'b0, 16'h0020, 16'h0000});
    exp_dm.push_back(16'hABCD);
    run_op("long", 21, 1, 0);
    check("long_cnt_main", stall_cycles, 23);
    check("long_cnt_sat", s_stall_cycles, 4'hF);
    next_cycle();
    clear_inputs();
    next_cycle();
    #1;
    check("hold_cnt_main", stall_cycles, 23);
    check("hold_cnt_sat", s_stall_cycles, 4'hF);

    // Plain fetch with no data traffic.
    next_cycle();
    lat = 1;
    if_req = 1'b1; if_addr = 16'h0010;
    exp_acc.push_back('{1'b0, 16'h0010, 16'h0000});
    exp_if.push_back(16'hBEEF);
    run_op("fetch", 2, 0, 1);
    next_cycle();
    clear_inputs();
    next_cycle();

    check("scoreboard_drained", exp_acc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
